// File: rtl/mw_stage_elastic.sv
// mw_stage_elastic: elastic Memory-Writeback stage with a 2-entry skid buffer, flush and writeback select
module mw_stage_elastic #(
  parameter int V = 128,
  parameter int N = 32,
  parameter int M = 4,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         valid_M,
  output logic         ready_M,
  input  logic         regw_M,
  input  logic         regmem_M,
  input  logic [M-1:0] regScr_M,
  input  logic [N-1:0] ALUrslt_M,
  input  logic [N-1:0] readdata_M,
  input  logic [V-1:0] regVrslt_M,
  input  logic [L-1:0] lanemask_M,
  output logic         valid_W,
  input  logic         ready_W,
  output logic         regw_W,
  output logic         regmem_W,
  output logic [M-1:0] regScr_W,
  output logic [N-1:0] ALUrslt_W,
  output logic [N-1:0] readdata_W,
  output logic [V-1:0] regVrslt_W,
  output logic [L-1:0] lanemask_W,
  output logic [N-1:0] wbdata_W,
  output logic [L-1:0] vwen_W,
  output logic [1:0]   occ
);
  localparam int P = 2 + M + 2*N + V + L;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [P-1:0] main_q, main_d, skid_q, skid_d, in_p;
  logic acc, pop, regw_s;
  assign in_p    = {regw_M, regmem_M, regScr_M, ALUrslt_M, readdata_M, regVrslt_M, lanemask_M};
  assign ready_M = (state_q != FULL) & ~rst;
  assign valid_W = state_q != EMPTY;
  assign acc     = valid_M & ready_M;
  assign pop     = valid_W & ready_W;
  assign {regw_s, regmem_W, regScr_W, ALUrslt_W, readdata_W, regVrslt_W, lanemask_W} = main_q;
  assign regw_W   = regw_s & valid_W;
  assign wbdata_W = regmem_W ? readdata_W : ALUrslt_W;
  assign vwen_W   = lanemask_W & {L{regw_W}};
  assign occ      = state_q == FULL ? 2'd2 : state_q == ONE ? 2'd1 : 2'd0;
  // next state and payload movement; flush empties the stage and ignores this cycle's handshakes
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (acc) begin
          state_d = ONE;
          main_d  = in_p;
        end
        ONE: if (acc && pop) main_d = in_p;
        else if (acc) begin
          state_d = FULL;
          skid_d  = in_p;
        end
        else if (pop) state_d = EMPTY;
        FULL: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
  end
  // state and payload registers, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_mw_stage_elastic.sv
// tb_mw_stage_elastic: randomized FIFO-model check of two stage configurations driven in lockstep
module tb_mw_stage_elastic;
  typedef struct {
    logic         regw;
    logic         regmem;
    logic [4:0]   scr;
    logic [63:0]  alu;
    logic [63:0]  rd;
    logic [255:0] vr;
    logic [7:0]   lm;
  } ent_t;
  logic clk = 0, rst, flush, valid_M, ready_W;
  ent_t cur;
  ent_t q[$];
  ent_t bp[3];
  logic [31:0] pops[$];
  bit rz, acc;
  int n_chk = 0, n_fail = 0;
  logic a_ready_M, a_valid_W, a_regw_W, a_regmem_W;
  logic [3:0] a_regScr_W, a_lanemask_W, a_vwen_W;
  logic [31:0] a_ALUrslt_W, a_readdata_W, a_wbdata_W;
  logic [127:0] a_regVrslt_W;
  logic [1:0] a_occ;
  logic b_ready_M, b_valid_W, b_regw_W, b_regmem_W;
  logic [4:0] b_regScr_W;
  logic [7:0] b_lanemask_W, b_vwen_W;
  logic [63:0] b_ALUrslt_W, b_readdata_W, b_wbdata_W;
  logic [255:0] b_regVrslt_W;
  logic [1:0] b_occ;
  always #5 clk = ~clk;
  mw_stage_elastic dut_a (
    .clk(clk), .rst(rst), .flush(flush), .valid_M(valid_M), .ready_M(a_ready_M),
    .regw_M(cur.regw), .regmem_M(cur.regmem), .regScr_M(cur.scr[3:0]),
    .ALUrslt_M(cur.alu[31:0]), .readdata_M(cur.rd[31:0]), .regVrslt_M(cur.vr[127:0]),
    .lanemask_M(cur.lm[3:0]), .valid_W(a_valid_W), .ready_W(ready_W), .regw_W(a_regw_W),
    .regmem_W(a_regmem_W), .regScr_W(a_regScr_W), .ALUrslt_W(a_ALUrslt_W),
    .readdata_W(a_readdata_W), .regVrslt_W(a_regVrslt_W), .lanemask_W(a_lanemask_W),
    .wbdata_W(a_wbdata_W), .vwen_W(a_vwen_W), .occ(a_occ)
  );
  mw_stage_elastic #(.V(256), .N(64), .M(5), .L(8)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .valid_M(valid_M), .ready_M(b_ready_M),
    .regw_M(cur.regw), .regmem_M(cur.regmem), .regScr_M(cur.scr),
    .ALUrslt_M(cur.alu), .readdata_M(cur.rd), .regVrslt_M(cur.vr),
    .lanemask_M(cur.lm), .valid_W(b_valid_W), .ready_W(ready_W), .regw_W(b_regw_W),
    .regmem_W(b_regmem_W), .regScr_W(b_regScr_W), .ALUrslt_W(b_ALUrslt_W),
    .readdata_W(b_readdata_W), .regVrslt_W(b_regVrslt_W), .lanemask_W(b_lanemask_W),
    .wbdata_W(b_wbdata_W), .vwen_W(b_vwen_W), .occ(b_occ)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ent_t rnd_ent();
    ent_t e;
    e.regw   = 1'($urandom_range(0, 1));
    e.regmem = 1'($urandom_range(0, 1));
    e.scr    = 5'($urandom);
    e.alu    = {$urandom, $urandom};
    e.rd     = {$urandom, $urandom};
    for (int k = 0; k < 8; k++) e.vr[k*32 +: 32] = $urandom;
    e.lm     = 8'($urandom);
    return e;
  endfunction
  task automatic check_out();
    ent_t e;
    logic [1:0] n;
    logic rdy;
    n   = 2'(q.size());
    rdy = (q.size() < 2) && !rst;
    check("occ_a", a_occ, n);
    check("occ_b", b_occ, n);
    check("valid_W_a", a_valid_W, n != 0);
    check("valid_W_b", b_valid_W, n != 0);
    check("ready_M_a_post", a_ready_M, rdy);
    check("ready_M_b_post", b_ready_M, rdy);
    if (n != 0) begin
      e = q[0];
      check("regw_W_a", a_regw_W, e.regw);
      check("regw_W_b", b_regw_W, e.regw);
      check("regmem_W_a", a_regmem_W, e.regmem);
      check("regScr_W_a", a_regScr_W, e.scr[3:0]);
      check("regScr_W_b", b_regScr_W, e.scr);
      check("ALUrslt_W_a", a_ALUrslt_W, e.alu[31:0]);
      check("readdata_W_b", b_readdata_W, e.rd);
      check("regVrslt_W_a", a_regVrslt_W, e.vr[127:0]);
      check("regVrslt_W_b", b_regVrslt_W, e.vr);
      check("wbdata_W_a", a_wbdata_W, e.regmem ? e.rd[31:0] : e.alu[31:0]);
      check("wbdata_W_b", b_wbdata_W, e.regmem ? e.rd : e.alu);
      check("vwen_W_a", a_vwen_W, e.regw ? e.lm[3:0] : 4'd0);
      check("vwen_W_b", b_vwen_W, e.regw ? e.lm : 8'd0);
    end else begin
      check("regw_W_a_idle", a_regw_W, 1'b0);
      check("regw_W_b_idle", b_regw_W, 1'b0);
      check("vwen_W_a_idle", a_vwen_W, 4'd0);
      check("vwen_W_b_idle", b_vwen_W, 8'd0);
      if (rz) begin
        check("wbdata_W_a_rst", a_wbdata_W, 32'd0);
        check("wbdata_W_b_rst", b_wbdata_W, 64'd0);
        check("regVrslt_W_a_rst", a_regVrslt_W, 128'd0);
        check("lanemask_W_b_rst", b_lanemask_W, 8'd0);
        check("regScr_W_a_rst", a_regScr_W, 4'd0);
      end
    end
  endtask
  task automatic step(output bit accepted);
    bit rdy, pop;
    #1;
    rdy = (q.size() < 2) && !rst;
    check("ready_M_a", a_ready_M, rdy);
    check("ready_M_b", b_ready_M, rdy);
    pop = (q.size() > 0) && ready_W;
    if (pop) pops.push_back(a_ALUrslt_W);
    accepted = valid_M && rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      rz = 1;
    end else if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (accepted) begin
        q.push_back(cur);
        rz = 0;
      end
    end
    #1;
    check_out();
  endtask
  initial begin
    rst = 1; flush = 0; valid_M = 0; ready_W = 0; cur = rnd_ent();
    repeat (2) @(posedge clk);
    #1;
    rz = 1;
    check_out();
    rst = 0;
    for (int i = 1; i <= 8; i++) begin
      valid_M = 1; ready_W = 1; cur = rnd_ent(); cur.alu = 64'(i); cur.regmem = 0;
      step(acc);
    end
    valid_M = 0;
    step(acc);
    for (int k = 0; k < 3; k++) bp[k] = rnd_ent();
    pops.delete();
    begin
      int idx = 0;
      for (int c = 0; c < 10; c++) begin
        valid_M = idx < 3;
        if (idx < 3) cur = bp[idx];
        ready_W = !(c >= 1 && c <= 3);
        step(acc);
        if (acc) idx++;
      end
    end
    check("bp_pop_count", 256'(pops.size()), 256'(3));
    for (int k = 0; k < 3; k++)
      if (k < pops.size()) check("bp_order", pops[k], bp[k].alu[31:0]);
    valid_M = 1; ready_W = 1; cur = rnd_ent();
    cur.regmem = 1; cur.rd = 64'hDEADBEEF; cur.alu = 64'h1; cur.regw = 1; cur.lm = 8'b1010;
    step(acc);
    check("ldsel_wbdata", a_wbdata_W, 32'hDEADBEEF);
    check("ldsel_vwen", a_vwen_W, 4'b1010);
    cur.regw = 0;
    step(acc);
    check("ldsel_vwen_off", a_vwen_W, 4'b0000);
    valid_M = 0;
    step(acc);
    ready_W = 0; valid_M = 1;
    repeat (2) begin
      cur = rnd_ent();
      step(acc);
    end
    flush = 1; ready_W = 1; cur = rnd_ent();
    step(acc);
    check("flush_occ", a_occ, 2'd0);
    flush = 0; valid_M = 0;
    step(acc);
    ready_W = 0; valid_M = 1;
    repeat (2) begin
      cur = rnd_ent();
      step(acc);
    end
    rst = 1;
    step(acc);
    rst = 0; valid_M = 0;
    step(acc);
    repeat (2000) begin
      valid_M = 1'($urandom_range(0, 1));
      ready_W = $urandom_range(0, 3) != 0;
      flush   = $urandom_range(0, 19) == 0;
      rst     = $urandom_range(0, 49) == 0;
      cur     = rnd_ent();
      step(acc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
